// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer (boot, stall, branch redirect + flush, halt/resume).
// Perf counters fetch_count/stall_count exist only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
  parameter int ARQ = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int FLUSH_CYCLES = 2,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_req,
  input  logic br_taken,
  input  logic [MEMORY_ADDR_SIZE-1:0] br_target,
  input  logic [ARQ-1:0] instr,
  input  logic resume,
  output logic pc_en,
  output logic mux_sel,
  output logic [MEMORY_ADDR_SIZE-1:0] branch_addr,
  output logic if_valid,
  output logic flush,
  output logic halted,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
);
  typedef enum logic [2:0] {BOOT, RUN, REDIRECT, FLUSH, HALT} state_t;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  state_t state;
  logic [2:0] cnt;
  logic run, halt_op, unused_bits;
  assign run = state == RUN;
  assign halt_op = instr[ARQ-1 -: 4] == HALT_OPCODE;
  assign unused_bits = ^instr[ARQ-5:0];
  always_comb begin
    pc_en = run ? (br_taken | ~stall_req) : state == REDIRECT;
    mux_sel = state == REDIRECT;
    if_valid = run;
    flush = state == REDIRECT || state == FLUSH;
    halted = state == HALT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= BOOT;
      cnt <= '0;
      branch_addr <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN:
          if (br_taken) begin
            branch_addr <= br_target;
            state <= REDIRECT;
          end else if (halt_op && !stall_req) state <= HALT;
        REDIRECT: begin
          cnt <= FLUSH_LOAD;
          state <= FLUSH_LOAD != 3'd0 ? FLUSH : RUN;
        end
        FLUSH: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= RUN;
        end
        HALT: if (resume) state <= RUN;
        default: state <= BOOT;
      endcase
    end
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] fetch_q, stall_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (run && pc_en && !mux_sel && fetch_q != 16'hFFFF) fetch_q <= fetch_q + 16'd1;
      if (run && stall_req && !br_taken && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  assign fetch_count = fetch_q;
  assign stall_count = stall_q;
`else
  assign fetch_count = 16'h0;
  assign stall_count = 16'h0;
`endif
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Each cycle it drives the PC enable, the next-PC mux select and the registered branch target. It handles boot after reset, decode stalls, taken-branch redirects with downstream flush, and halt/resume. It sits between the hazard/branch logic of later stages and the fetch datapath (PC register, +1 incrementer, PC mux, instruction memory).

## Interface
Parameters:
- ARQ, 16, instruction width
- MEMORY_ADDR_SIZE, 13, instruction address width
- FLUSH_CYCLES, 2, cycles `flush` is held per redirect (legal 1..7)
- HALT_OPCODE, 4'hF, value of `instr[ARQ-1:ARQ-4]` that halts fetch

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_req  in  1  decode hazard; hold PC this cycle
- br_taken  in  1  branch resolved taken (single-cycle pulse)
- br_target  in  MEMORY_ADDR_SIZE  branch destination, valid with `br_taken`
- instr  in  ARQ  current instruction-memory output
- resume  in  1  leave HALT
- pc_en  out  1  PC register load enable
- mux_sel  out  1  0 = PC+1, 1 = branch_addr
- branch_addr  out  MEMORY_ADDR_SIZE  registered redirect target
- if_valid  out  1  `instr` is a valid, in-path instruction
- flush  out  1  clear downstream pipeline registers
- halted  out  1  fetch halted
- fetch_count  out  16  perf: committed fetches
- stall_count  out  16  perf: stalled RUN cycles

## Operation
- States: BOOT, RUN, REDIRECT, FLUSH, HALT.
- Outputs are decoded from state, plus `stall_req` in RUN. `branch_addr` and the flush counter are registers.
- Reset (async): state=BOOT, branch_addr=0, flush counter=0, counters=0.
  - Outputs during and immediately after reset: pc_en=0, mux_sel=0, if_valid=0, flush=0, halted=0.
- BOOT: pc_en=0, if_valid=0; exactly one cycle, then RUN. This lets the memory present address 0.
- RUN: mux_sel=0, pc_en=~stall_req, if_valid=1. Priority, highest first:
  - br_taken: branch_addr<=br_target, next state REDIRECT; `stall_req` is ignored for pc_en that cycle.
  - Halt: opcode==HALT_OPCODE and ~stall_req; next state HALT. PC advances past the halt instruction.
  - Otherwise stay in RUN.
- REDIRECT (1 cycle):
  - pc_en=1, mux_sel=1, if_valid=0, flush=1; the flush counter loads FLUSH_CYCLES-1.
  - Next state FLUSH if the loaded value is nonzero, else RUN.
- FLUSH:
  - pc_en=0, mux_sel=0, if_valid=0, flush=1.
  - The counter decrements each cycle; when it reaches 0, RUN next cycle.
- HALT:
  - pc_en=0, if_valid=0, halted=1.
  - resume=1 means RUN next cycle; `stall_req` is ignored.
- br_taken outside RUN is ignored; it comes from wrong-path or halted state.
- Counters (saturating at 16'hFFFF):
  - fetch_count +1 on each RUN cycle with pc_en=1 and mux_sel=0.
  - stall_count +1 on each RUN cycle with stall_req=1 and br_taken=0.

## Timing
- Redirect, br_taken in RUN at cycle N:
  - N+1 (REDIRECT): mux_sel=1, pc_en=1; the PC loads br_target at the end of N+1.
  - N+2: instr = mem[br_target]; if_valid=1 from the first RUN cycle.
  - flush is high for exactly FLUSH_CYCLES cycles, N+1 .. N+FLUSH_CYCLES.
- Stall: combinational; pc_en drops in the same cycle stall_req rises. No added latency.
- Halt: detected at cycle N, halted=1 from N+1. resume at cycle M gives RUN at M+1 with pc_en=1.
- rst mid-redirect or mid-flush: immediately BOOT and all outputs at reset values. branch_addr clears to 0.

## Configuration
- FETCH_CTRL_PERF_EN defined: `fetch_count` and `stall_count` implemented as above.
- FETCH_CTRL_PERF_EN undefined:
  - Both counters and their logic are removed; the outputs are tied to 16'h0.
  - All other behaviour is identical.

## Test plan
- Reset release:
  - Cycle 1: pc_en=0, if_valid=0.
  - Cycle 2: pc_en=1, mux_sel=0, if_valid=1.
  - fetch_count=1 after cycle 2.
- stall_req high for 3 RUN cycles:
  - pc_en=0 for exactly those 3 cycles; stall_count=3; fetch_count unchanged.
- br_taken with br_target=13'h0A5, FLUSH_CYCLES=2:
  - Next cycle: mux_sel=1, branch_addr=13'h0A5.
  - flush high for 2 cycles; if_valid=0 for 2 cycles, then 1.
- br_taken and stall_req together in RUN:
  - REDIRECT is entered; the stall is ignored; stall_count is not incremented.
- instr=16'hF000 in RUN:
  - halted=1 next cycle; pc_en=0 held for 10 cycles; br_taken during HALT has no effect.
  - resume pulse gives RUN next cycle.
- rst asserted during FLUSH:
  - All outputs return to reset values immediately; branch_addr=0.
  - With FETCH_CTRL_PERF_EN undefined, counters read 0 throughout.
